// File: rtl/ms_spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and wire-format constants for the SPI flash responder.
package ms_spi_flash_pkg;

    localparam int unsigned WIRE_ADDR_W = 24;
    localparam int unsigned CNT_W       = 5;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/ms_spi_sync_edge.sv
// Two-flop synchronizer with a third stage for rise/fall detection.
module ms_spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic s1_q, s2_q, s3_q;

    // Synchronizer chain; all stages share the reset value so reset never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o  = s2_q;
    assign rise_c_o = s2_q & ~s3_q;
    assign fall_c_o = ~s2_q & s3_q;

endmodule

// File: rtl/ms_spi_flash_responder.sv
// SPI mode-0 flash slave: serves READ, FAST_READ and JEDEC-ID from a synchronous byte memory.
module ms_spi_flash_responder
    import ms_spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W    = 24,
    parameter logic [23:0] JEDEC_ID  = 24'hBF2658,
    parameter int unsigned DUMMY_CYC = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              sck,
    input  logic              ce_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);

    logic sck_lvl, sck_rise_c, sck_fall_c;
    logic ce_lvl, ce_rise_c, ce_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic unused_c;

    ms_spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk_i(HCLK), .rst_ni(HRESETn), .d_i(sck),
        .level_o(sck_lvl), .rise_c_o(sck_rise_c), .fall_c_o(sck_fall_c)
    );

    ms_spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ce (
        .clk_i(HCLK), .rst_ni(HRESETn), .d_i(ce_n),
        .level_o(ce_lvl), .rise_c_o(ce_rise_c), .fall_c_o(ce_fall_c)
    );

    ms_spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(HCLK), .rst_ni(HRESETn), .d_i(mosi),
        .level_o(mosi_lvl), .rise_c_o(mosi_rise_c), .fall_c_o(mosi_fall_c)
    );

    assign unused_c = ^{sck_lvl, mosi_rise_c, mosi_fall_c};

    state_e                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [7:0]             cmd_q;
    logic [WIRE_ADDR_W-2:0] addr_sh_q;
    logic [7:0]             tx_q;
    logic [7:0]             buf_q;
    logic [23:0]            id_sh_q;
    logic                   rd_dly_q;
    logic                   miso_q, miso_oe_q, mem_rd_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [1:0]             settle_q;
    logic                   armed_q;

    logic                   rise_act_c, fall_act_c;
    logic [7:0]             cmd_nxt_c;
    logic [WIRE_ADDR_W-1:0] addr_nxt_c;

    // SCK edges only count while the chip is selected.
    assign rise_act_c = sck_rise_c & ~ce_lvl;
    assign fall_act_c = sck_fall_c & ~ce_lvl;
    assign cmd_nxt_c  = {cmd_q[6:0], mosi_lvl};
    assign addr_nxt_c = {addr_sh_q, mosi_lvl};

    // Frame-start qualifier: a ce_n already low when reset releases must not open a frame.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd2 && ce_lvl) armed_q <= 1'b1;
        end
    end

    // Protocol FSM with registered miso / memory-port outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_sh_q  <= '0;
            tx_q       <= '0;
            buf_q      <= '0;
            id_sh_q    <= '0;
            rd_dly_q   <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_rd_q <= 1'b0;
            rd_dly_q <= mem_rd_q;
            if (rd_dly_q && state_q != ST_IDLE) buf_q <= mem_rdata;

            if (ce_rise_c) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                cmd_q     <= '0;
                addr_sh_q <= '0;
                tx_q      <= '0;
                buf_q     <= '0;
                id_sh_q   <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ce_fall_c && armed_q) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (rise_act_c) begin
                            cmd_q <= cmd_nxt_c;
                            if (bit_cnt_q == CNT_W'(7)) begin
                                bit_cnt_q <= '0;
                                if (cmd_nxt_c == CMD_READ || cmd_nxt_c == CMD_FAST_READ) begin
                                    state_q <= ST_ADDR;
                                end else if (cmd_nxt_c == CMD_RDID) begin
                                    state_q   <= ST_ID;
                                    id_sh_q   <= JEDEC_ID;
                                    miso_oe_q <= 1'b1;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_act_c) begin
                            addr_sh_q <= addr_nxt_c[WIRE_ADDR_W-2:0];
                            if (bit_cnt_q == CNT_W'(WIRE_ADDR_W - 1)) begin
                                bit_cnt_q  <= '0;
                                mem_addr_q <= addr_nxt_c[ADDR_W-1:0];
                                mem_rd_q   <= 1'b1;
                                if (cmd_q == CMD_FAST_READ) begin
                                    state_q <= ST_DUMMY;
                                end else begin
                                    state_q   <= ST_DATA;
                                    miso_oe_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (rise_act_c) begin
                            if (bit_cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_DATA;
                                miso_oe_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (fall_act_c) begin
                            // Byte boundary: present bit 7 of the buffered byte and prefetch the next one.
                            if (bit_cnt_q[2:0] == 3'd0) begin
                                miso_q     <= buf_q[7];
                                tx_q       <= {buf_q[6:0], 1'b0};
                                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                                mem_rd_q   <= 1'b1;
                            end else begin
                                miso_q <= tx_q[7];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end
                            bit_cnt_q <= CNT_W'(3'(bit_cnt_q[2:0] + 3'd1));
                        end
                    end
                    ST_ID: begin
                        if (fall_act_c) begin
                            miso_q  <= id_sh_q[23];
                            id_sh_q <= {id_sh_q[22:0], 1'b0};
                        end
                    end
                    ST_IGNORE: begin
                        miso_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: doc/ms_spi_flash_responder.md
Name: ms_spi_flash_responder

Overview:
Synthesizable SPI serial-flash responder. It is the slave end of the SPI read protocol that the XIP cache issues as master. It decodes READ (0x03), FAST_READ (0x0B) and JEDEC-ID (0x9F) frames and serves data bytes from a synchronous byte-wide memory port. It is used as an on-chip boot-ROM front end, and as a synthesizable flash replacement in system benches and FPGA builds.

Parameters:
ADDR_W, 24, flash address width; wire address is always 24 bits, low ADDR_W bits are used.
JEDEC_ID, 24'hBF2658, bytes returned by 0x9F, MSB first.
DUMMY_CYC, 8, dummy SCK cycles after the address for 0x0B.

Ports:
HCLK  in  1  system clock; all logic is on its rising edge.
HRESETn  in  1  asynchronous active-low reset.
sck  in  1  SPI clock from master; asynchronous to HCLK.
ce_n  in  1  SPI chip enable, active low.
mosi  in  1  serial data from master.
miso  out  1  serial data to master.
miso_oe  out  1  output enable for the miso pad.
mem_rd  out  1  one-cycle read strobe.
mem_addr  out  ADDR_W  byte address.
mem_rdata  in  8  read data, valid exactly 1 HCLK after mem_rd.

Behaviour:
- Clocking constraint: SCK frequency must be no higher than HCLK/16. SPI mode 0 only: mosi is sampled on the SCK rise; miso changes on the SCK fall.
- Synchronizers: sck, ce_n and mosi each pass through 2-FF synchronizers. The ce_n synchronizer resets to 1; sck and mosi reset to 0. Edges are detected from a 3rd registered stage.
- Reset values: miso=0, miso_oe=0, mem_rd=0, mem_addr=0, state=IDLE, all counters and shift registers 0.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- IDLE: a ce_n fall moves to CMD and clears the bit counter.
- CMD: shifts 8 mosi bits MSB first.
  - 0x03 goes to ADDR.
  - 0x0B goes to ADDR; DUMMY follows.
  - 0x9F goes to ID and preloads the JEDEC_ID shifter.
  - Any other value goes to IGNORE.
- ADDR: shifts 24 bits MSB first.
  - After the 24th rise: if the command was 0x03, go to DATA; if 0x0B, go to DUMMY.
  - In both cases, issue mem_rd with mem_addr = addr[ADDR_W-1:0] within 1 HCLK of detecting that edge.
- DUMMY: counts DUMMY_CYC SCK rises and ignores mosi, then goes to DATA.
- DATA:
  - The byte fetched as above is loaded into the tx shifter. miso_oe=1, and bit 7 is driven on the first SCK fall after entering DATA.
  - Each SCK fall shifts the next bit out.
  - On the fall that presents bit 7 of a byte, the address increments and a prefetch mem_rd is issued for the following byte. The result is held in a 1-byte buffer and loaded at the byte boundary.
  - Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- ID:
  - Outputs the 3 JEDEC_ID bytes MSB first on SCK falls, with miso_oe=1.
  - Further clocks output 0x00.
  - No mem_rd is issued.
- IGNORE: miso_oe=0 and no mem_rd until ce_n rises.
- ce_n rise (synchronized), from any state:
  - next cycle: state=IDLE, miso_oe=0, miso=0;
  - any pending prefetch result is discarded;
  - partial command or address bits are discarded.
- Simultaneous events: ce_n rise has priority over a same-cycle SCK edge. A ce_n fall while already active is impossible and needs no handling.
- HRESETn asserted mid-frame: all outputs take reset values immediately. After release, the block waits in IDLE for a fresh ce_n fall; an already-low ce_n is not treated as a frame start.
- SCK edges while ce_n is high are ignored.

Decomposition:
- Shared package ms_spi_flash_pkg:
  - command opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, CMD_RDID=8'h9F;
  - FSM state enum;
  - wire address width constant 24.
- One sub-module: ms_spi_sync_edge. It is a 2-FF synchronizer plus rise/fall detector with a reset-value parameter, instantiated 3 times.

Test Plan:
Memory model is a synchronous ROM with byte[i] = i[7:0]; SCK = HCLK/20.
1. READ: 0x03, addr 0x000000, 16 bytes clocked -> 00,01,...,0F; grouped little-endian this is 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; exactly 17 mem_rd pulses (16 plus 1 prefetch).
2. FAST_READ: 0x0B, addr 0x000020, 8 dummy clocks, 4 bytes -> 20,21,22,23; miso_oe stays 0 through DUMMY.
3. JEDEC ID: 0x9F, 4 bytes -> BF,26,58,00; no mem_rd.
4. Wrap: 0x03, addr 0xFFFFFE, 4 bytes -> FE,FF,00,01; mem_addr sequence FFFFFE, FFFFFF, 000000, 000001, 000002.
5. Abort/unknown, two frames:
   - 0xAB frame, 16 clocks -> miso_oe=0, no mem_rd;
   - then 0x03 aborted by ce_n high after 12 address bits;
   - then 0x03, addr 0x000004, 2 bytes -> 04,05.
6. Reset mid-DATA: HRESETn low during byte 2 -> miso_oe=0 within 1 HCLK; after release with ce_n still low, SCK toggles produce no output; a new frame 0x03, addr 0x10 -> 10,11.
